// File: rtl/time_disp_scan.sv
// rtl/time_disp_scan.sv - six-digit multiplexed 7-segment scanner for BCD hh:mm:ss
// Inputs are snapshotted once per frame; one field can blink for time-set mode.
module time_disp_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [1:0] blink_sel,
  input  logic       dp_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic          started;
  logic          wrap_d;
  logic [7:0]    hour_s, min_s, sec_s;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [1:0]    sel_q;

  logic          terminal;
  logic          wrap;
  logic          sel_change;
  logic          blank;
  logic [7:0]    hour_src, min_src, sec_src;
  logic [3:0]    digit;
  logic [6:0]    seg_next;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  assign terminal   = (div == DW'(SCAN_DIV - 1));
  assign wrap       = started && terminal && (idx == 3'd5);
  assign sel_change = (blink_sel != sel_q);

  // On the very first edge after reset the snapshot is still loading, so the
  // first idx0 output is taken straight from the inputs being captured.
  always_comb begin
    hour_src = started ? hour_s : hour;
    min_src  = started ? min_s  : min;
    sec_src  = started ? sec_s  : sec;
    case (idx)
      3'd0:    digit = sec_src[3:0];
      3'd1:    digit = sec_src[7:4];
      3'd2:    digit = min_src[3:0];
      3'd3:    digit = min_src[7:4];
      3'd4:    digit = hour_src[3:0];
      3'd5:    digit = hour_src[7:4];
      default: digit = 4'hF;
    endcase
    seg_next = decode(digit);
    // Field index idx[2:1]: 0 sec, 1 min, 2 hour; blink_sel 11/10/01 maps to 0/1/2.
    blank = phase && !sel_change && (blink_sel != 2'b00) &&
            ((2'd3 - blink_sel) == idx[2:1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div        <= '0;
      idx        <= 3'd0;
      started    <= 1'b0;
      wrap_d     <= 1'b0;
      hour_s     <= 8'h00;
      min_s      <= 8'h00;
      sec_s      <= 8'h00;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      sel_q      <= 2'b00;
      an         <= 6'b111111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      started    <= 1'b1;
      sel_q      <= blink_sel;
      wrap_d     <= wrap;
      frame_done <= wrap_d;

      if (!started || wrap) begin
        hour_s <= hour;
        min_s  <= min;
        sec_s  <= sec;
      end

      if (terminal) begin
        div <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        div <= div + DW'(1);
      end

      if (sel_change) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (wrap) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (blank) begin
        an  <= 6'b111111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(6'b000001 << idx);
        seg <= seg_next;
        dp  <= ~(dp_en && ((idx == 3'd2) || (idx == 3'd4)));
      end
    end
  end

endmodule

// File: tb/tb_time_disp_scan.sv
// tb/tb_time_disp_scan.sv - self-checking bench for time_disp_scan
module tb_time_disp_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hour = 8'h00;
  logic [7:0] min = 8'h00;
  logic [7:0] sec = 8'h00;
  logic [1:0] blink_sel = 2'b00;
  logic       dp_en = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int n_checks = 0;
  int n_pass = 0;
  int e = 0;

  always #5 clk = ~clk;

  time_disp_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec),
    .blink_sel(blink_sel), .dp_en(dp_en), .an(an), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       dp_en;
    int         idx;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [5:0] ea, input logic [6:0] es, input logic ed);
    check({name, ".an"}, {26'd0, an}, {26'd0, ea});
    check({name, ".seg"}, {25'd0, seg}, {25'd0, es});
    check({name, ".dp"}, {31'd0, dp}, {31'd0, ed});
  endtask

  // Reset, load inputs, release on a falling edge; e counts edges since release.
  task automatic restart(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         input logic d, input logic [1:0] b);
    @(negedge clk);
    rst = 1'b1;
    hour = h; min = m; sec = s; dp_en = d; blink_sel = b;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e = 0;
  endtask

  task automatic goto(input int t);
    repeat (t - e) @(posedge clk);
    e = t;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_fd;
    int second_fd;
    int n_fd;

    vecs[0]  = '{8'h16, 8'h59, 8'h07, 1'b1, 0, 6'b111110, 7'b1111000, 1'b1};
    vecs[1]  = '{8'h16, 8'h59, 8'h07, 1'b1, 1, 6'b111101, 7'b1000000, 1'b1};
    vecs[2]  = '{8'h16, 8'h59, 8'h07, 1'b1, 2, 6'b111011, 7'b0010000, 1'b0};
    vecs[3]  = '{8'h16, 8'h59, 8'h07, 1'b1, 3, 6'b110111, 7'b0010010, 1'b1};
    vecs[4]  = '{8'h16, 8'h59, 8'h07, 1'b1, 4, 6'b101111, 7'b0000010, 1'b0};
    vecs[5]  = '{8'h16, 8'h59, 8'h07, 1'b1, 5, 6'b011111, 7'b1111001, 1'b1};
    vecs[6]  = '{8'h1A, 8'h00, 8'h35, 1'b0, 0, 6'b111110, 7'b0010010, 1'b1};
    vecs[7]  = '{8'h1A, 8'h00, 8'h35, 1'b0, 1, 6'b111101, 7'b0110000, 1'b1};
    vecs[8]  = '{8'h1A, 8'h00, 8'h35, 1'b0, 2, 6'b111011, 7'b1000000, 1'b1};
    vecs[9]  = '{8'h1A, 8'h00, 8'h35, 1'b0, 3, 6'b110111, 7'b1000000, 1'b1};
    vecs[10] = '{8'h1A, 8'h00, 8'h35, 1'b0, 4, 6'b101111, 7'b1111111, 1'b1};
    vecs[11] = '{8'h1A, 8'h00, 8'h35, 1'b0, 5, 6'b011111, 7'b1111001, 1'b1};
    vecs[12] = '{8'h28, 8'h47, 8'hF9, 1'b1, 0, 6'b111110, 7'b0010000, 1'b1};
    vecs[13] = '{8'h28, 8'h47, 8'hF9, 1'b1, 1, 6'b111101, 7'b1111111, 1'b1};
    vecs[14] = '{8'h28, 8'h47, 8'hF9, 1'b1, 2, 6'b111011, 7'b1111000, 1'b0};
    vecs[15] = '{8'h28, 8'h47, 8'hF9, 1'b1, 3, 6'b110111, 7'b0011001, 1'b1};
    vecs[16] = '{8'h28, 8'h47, 8'hF9, 1'b1, 4, 6'b101111, 7'b0000000, 1'b0};
    vecs[17] = '{8'h28, 8'h47, 8'hF9, 1'b1, 5, 6'b011111, 7'b0100100, 1'b1};

    // Held in reset from time zero.
    @(negedge clk);
    check_out("reset_init", 6'b111111, 7'b1111111, 1'b1);
    check("reset_init.fd", {31'd0, frame_done}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      restart(vecs[i].hour, vecs[i].min, vecs[i].sec, vecs[i].dp_en, 2'b00);
      goto(4 * vecs[i].idx + 1);
      check_out($sformatf("vec%0d_idx%0d", i, vecs[i].idx), vecs[i].an, vecs[i].seg, vecs[i].dp);
    end

    // Asynchronous reset mid-cycle, away from any clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_out("reset_async", 6'b111111, 7'b1111111, 1'b1);
    check("reset_async.fd", {31'd0, frame_done}, 32'd0);

    // frame_done cadence: first pulse with frame 1 idx0, then every 24 cycles.
    restart(8'h16, 8'h59, 8'h07, 1'b1, 2'b00);
    first_fd = -1; second_fd = -1; n_fd = 0;
    for (int k = 1; k <= 60; k++) begin
      goto(k);
      if (frame_done === 1'b1) begin
        n_fd++;
        if (first_fd < 0) first_fd = k;
        else if (second_fd < 0) second_fd = k;
      end
      if (k == 25) check_out("fd_frame1_idx0", 6'b111110, 7'b1111000, 1'b1);
    end
    check("fd_first", first_fd, 25);
    check("fd_second", second_fd, 49);
    check("fd_count", n_fd, 2);

    // Snapshot: mid-frame changes wait for the next frame.
    restart(8'h16, 8'h59, 8'h07, 1'b1, 2'b00);
    goto(13);
    check_out("snap_idx3", 6'b110111, 7'b0010010, 1'b1);
    sec = 8'h08;
    hour = 8'h21;
    goto(17);
    check_out("snap_old_hour", 6'b101111, 7'b0000010, 1'b0);
    goto(25);
    check_out("snap_new_sec", 6'b111110, 7'b0000000, 1'b1);
    goto(41);
    check_out("snap_new_hour1", 6'b101111, 7'b1111001, 1'b0);
    goto(45);
    check_out("snap_new_hour2", 6'b011111, 7'b0100100, 1'b1);

    // Blink minutes: frames 0-1 lit, 2-3 blanked, 4 lit.
    restart(8'h16, 8'h59, 8'h07, 1'b1, 2'b10);
    goto(9);
    check_out("blink_f0_idx2", 6'b111011, 7'b0010000, 1'b0);
    goto(37);
    check_out("blink_f1_idx3", 6'b110111, 7'b0010010, 1'b1);
    goto(49);
    check_out("blink_f2_idx0", 6'b111110, 7'b1111000, 1'b1);
    goto(57);
    check_out("blink_f2_idx2", 6'b111111, 7'b1111111, 1'b1);
    goto(85);
    check_out("blink_f3_idx3", 6'b111111, 7'b1111111, 1'b1);
    goto(105);
    check_out("blink_f4_idx2", 6'b111011, 7'b0010000, 1'b0);

    // Switch blink field during a blanked minute digit.
    restart(8'h16, 8'h59, 8'h07, 1'b1, 2'b10);
    goto(57);
    check_out("sw_blanked", 6'b111111, 7'b1111111, 1'b1);
    blink_sel = 2'b01;
    goto(58);
    check_out("sw_min_back", 6'b111011, 7'b0010000, 1'b0);
    goto(65);
    check_out("sw_f2_hour", 6'b101111, 7'b0000010, 1'b0);
    goto(89);
    check_out("sw_f3_hour", 6'b101111, 7'b0000010, 1'b0);
    goto(105);
    check_out("sw_f4_min", 6'b111011, 7'b0010000, 1'b0);
    goto(113);
    check_out("sw_f4_hour", 6'b111111, 7'b1111111, 1'b1);

    // Reset mid-frame at idx3, new input while held, scan restarts cleanly.
    restart(8'h16, 8'h59, 8'h07, 1'b1, 2'b00);
    goto(13);
    rst = 1'b1;
    #1;
    check_out("midrst_async", 6'b111111, 7'b1111111, 1'b1);
    sec = 8'h08;
    repeat (3) @(negedge clk);
    check_out("midrst_held", 6'b111111, 7'b1111111, 1'b1);
    rst = 1'b0;
    e = 0;
    goto(1);
    check_out("midrst_first", 6'b111110, 7'b0000000, 1'b1);
    check("midrst_fd_e1", {31'd0, frame_done}, 32'd0);
    goto(24);
    check("midrst_fd_e24", {31'd0, frame_done}, 32'd0);
    goto(25);
    check("midrst_fd_e25", {31'd0, frame_done}, 32'd1);
    goto(26);
    check("midrst_fd_e26", {31'd0, frame_done}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
